// File: rtl/store_buffer.sv
// Word-store buffer between the memory stage and data memory.
// Loads own the port; queued stores drain when it is free.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] exact;
  logic [DEPTH-1:0] near;

  logic                  enq;
  logic                  drain;
  logic                  ld_go;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Slot i is live when its distance from head is below count.
  always_comb begin
    live  = '0;
    exact = '0;
    near  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i]  = {1'b0, PW'(PW'(i) - head)} < count;
      exact[i] = live[i] && (addr_q[i] == ld_addr);
      near[i]  = live[i] && (addr_q[i] != ld_addr) &&
                 ((ADDR_WIDTH'(ld_addr - addr_q[i]) < ADDR_WIDTH'(4)) ||
                  (ADDR_WIDTH'(addr_q[i] - ld_addr) < ADDR_WIDTH'(4)));
    end
  end

  // Walk oldest to youngest so the youngest exact match wins.
  always_comb begin
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (exact[PW'(head + PW'(k))]) begin
        fwd_data = data_q[PW'(head + PW'(k))];
      end
    end
  end

  assign st_ready = (count != (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign enq      = st_valid && st_ready;

  assign ld_stall = ld_valid && (|near);
  assign ld_go    = ld_valid && !ld_stall;
  assign drain    = !ld_go && (count != '0);

  assign ld_data  = (|exact) ? fwd_data : mem_rd;
  assign mem_we   = drain;
  assign mem_addr = drain ? addr_q[head] : ld_addr;
  assign mem_wd   = data_q[head];

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      unique case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [16:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [16:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [16:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        empty;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [32768];
  ent_t        q[$];

  int errors = 0;
  int checks = 0;

  store_buffer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(17),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .st_valid(st_valid),
    .st_ready(st_ready),
    .st_addr(st_addr),
    .st_data(st_data),
    .ld_valid(ld_valid),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_stall(ld_stall),
    .empty(empty),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[16:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit is_near(logic [16:0] e, logic [16:0] l);
    logic [16:0] up;
    logic [16:0] dn;
    up = l - e;
    dn = e - l;
    return (e != l) && (up < 17'd4 || dn < 17'd4);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    foreach (q[i]) if (is_near(q[i].a, ld_addr)) s = 1'b1;
    return ld_valid && s;
  endfunction

  // Reference: flat queue in acceptance order plus a word memory.
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'hC0DE_0000 | i;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
      end else begin
        bit go;
        bit dr;
        bit en;
        go = ld_valid && !m_stall();
        dr = !go && q.size() != 0;
        en = st_valid && q.size() != DEPTH;
        if (mem_we) mem[mem_addr[16:2]] = mem_wd;
        if (dr) void'(q.pop_front());
        if (en) q.push_back('{a: st_addr, d: st_data});
      end
    end
  end

  initial begin
    forever begin
      bit          s;
      bit          go;
      bit          we;
      bit          hit;
      logic [31:0] fwd;
      @(negedge clk);
      s   = m_stall();
      go  = ld_valid && !s;
      we  = !go && q.size() != 0;
      hit = 1'b0;
      fwd = '0;
      foreach (q[i]) begin
        if (q[i].a == ld_addr) begin
          hit = 1'b1;
          fwd = q[i].d;
        end
      end
      chk("m_st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_ld_stall", 32'(ld_stall), 32'(s));
      chk("m_mem_we", 32'(mem_we), 32'(we));
      chk("m_mem_addr", 32'(mem_addr), we ? 32'(q[0].a) : 32'(ld_addr));
      if (we) chk("m_mem_wd", mem_wd, q[0].d);
      if (go) chk("m_ld_data", ld_data, hit ? fwd : mem[ld_addr[16:2]]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_ld(logic [16:0] a);
    ld_valid = 1'b1;
    ld_addr  = a;
  endtask

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    step();
    step();
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill while a load holds the port, then drain in order.
    hold_ld(17'h4000);
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1;
      st_addr  = 17'(32'h100 + 4 * i);
      st_data  = 32'hAAAA_0001 + i;
      @(negedge clk);
      step();
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_ready", 32'(st_ready), 32'd0);
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'h100 + 4 * i);
      step();
    end
    @(negedge clk);
    chk("drained_empty", 32'(empty), 32'd1);
    step();

    // Two stores to one address: youngest forwarded, both drain.
    hold_ld(17'h4000);
    st_valid = 1'b1;
    st_addr  = 17'h200;
    st_data  = 32'h1111_1111;
    step();
    st_data  = 32'h2222_2222;
    step();
    st_valid = 1'b0;
    ld_addr  = 17'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fwd_data", ld_data, 32'h2222_2222);
      chk("fwd_stall", 32'(ld_stall), 32'd0);
      chk("fwd_we", 32'(mem_we), 32'd0);
      step();
    end
    ld_valid = 1'b0;
    step();
    step();
    hold_ld(17'h200);
    @(negedge clk);
    chk("same_addr_mem", ld_data, 32'h2222_2222);
    step();
    ld_valid = 1'b0;

    // Partial overlap stalls one cycle while the store drains.
    st_valid = 1'b1;
    st_addr  = 17'h300;
    st_data  = 32'hDEAD_BEEF;
    step();
    st_valid = 1'b0;
    hold_ld(17'h302);
    @(negedge clk);
    chk("ovl_stall", 32'(ld_stall), 32'd1);
    chk("ovl_we", 32'(mem_we), 32'd1);
    chk("ovl_addr", 32'(mem_addr), 32'h300);
    step();
    @(negedge clk);
    chk("ovl_release", 32'(ld_stall), 32'd0);
    chk("ovl_data", ld_data, 32'hDEAD_BEEF);
    step();
    ld_valid = 1'b0;

    // Overlap across the top of the address space.
    st_valid = 1'b1;
    st_addr  = 17'h1FFFE;
    st_data  = 32'h1234_5678;
    step();
    st_valid = 1'b0;
    hold_ld(17'h0);
    @(negedge clk);
    chk("wrap_stall", 32'(ld_stall), 32'd1);
    step();
    @(negedge clk);
    chk("wrap_release", 32'(ld_stall), 32'd0);
    chk("wrap_data", ld_data, 32'hC0DE_0000);
    step();
    ld_valid = 1'b0;

    // Full buffer drains while a store waits.
    hold_ld(17'h4000);
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1;
      st_addr  = 17'(32'h500 + 4 * i);
      st_data  = 32'h5555_0000 + i;
      step();
    end
    ld_valid = 1'b0;
    st_addr  = 17'h510;
    st_data  = 32'h5555_0004;
    @(negedge clk);
    chk("fd_ready0", 32'(st_ready), 32'd0);
    chk("fd_we", 32'(mem_we), 32'd1);
    step();
    @(negedge clk);
    chk("fd_ready1", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    for (int n = 0; n < 20 && !empty; n++) step();
    chk("fd_empty", 32'(empty), 32'd1);
    hold_ld(17'h510);
    @(negedge clk);
    chk("fd_last", ld_data, 32'h5555_0004);
    step();
    ld_addr = 17'h50C;
    @(negedge clk);
    chk("fd_prev", ld_data, 32'h5555_0003);
    step();
    ld_valid = 1'b0;

    // Mid-cycle reset discards queued stores.
    hold_ld(17'h4000);
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1;
      st_addr  = 17'(32'h600 + 4 * i);
      st_data  = 32'h6666_0000 + i;
      step();
    end
    st_valid = 1'b0;
    ld_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ready", 32'(st_ready), 32'd1);
    hold_ld(17'h602);
    #1;
    chk("mid_rst_stall", 32'(ld_stall), 32'd0);
    ld_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    hold_ld(17'h600);
    @(negedge clk);
    chk("post_rst_600", ld_data, 32'hC0DE_0180);
    step();
    ld_addr = 17'h608;
    @(negedge clk);
    chk("post_rst_608", ld_data, 32'hC0DE_0182);
    step();
    ld_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
